// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it.
// Bit timing comes from a fractional phase accumulator.
module uart_tx_fifo #(
  parameter int SYSCLK_FREQ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  input  logic                          ovf_clr,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [28:0] INC       = 29'(BAUD_RATE);
  localparam logic [28:0] LIM       = 29'(SYSCLK_FREQ);
  localparam logic [7:0]  MASK      = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic        ODD       = (PARITY == 1);
  localparam logic        HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [28:0] acc_q, acc_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  mem_q [FIFO_DEPTH];

  logic [28:0] sum;
  logic        tick;
  logic        empty;
  logic        full;
  logic [7:0]  head;
  logic        last_stop;
  logic        pop;
  logic        push;
  logic        drop;

  assign sum       = acc_q + INC;
  assign tick      = (sum >= LIM);
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign head      = mem_q[rptr_q];
  assign last_stop = (state_q == STOP) && tick
                     && (stop_q == LAST_STOP);
  assign pop       = !empty && ((state_q == IDLE) || last_stop);
  assign push      = wr_en && (!full || pop);
  assign drop      = wr_en && full && !pop;

  always_comb begin
    state_d = state_q;
    acc_d   = tick ? (sum - LIM) : sum;
    sh_d    = sh_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    if (pop) begin
      // Load a frame; the start bit goes out on this same edge.
      state_d = START;
      acc_d   = '0;
      sh_d    = head;
      bit_d   = '0;
      stop_d  = 1'b0;
      par_d   = (^(head & MASK)) ^ ODD;
      tx_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          acc_d = '0;
          tx_d  = 1'b1;
        end
        START: begin
          if (tick) begin
            state_d = DATA;
            tx_d    = sh_q[0];
            sh_d    = sh_q >> 1;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_q == LAST_BIT) begin
              stop_d = 1'b0;
              if (HAS_PAR) begin
                state_d = PAR;
                tx_d    = par_q;
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              tx_d  = sh_q[0];
              sh_d  = sh_q >> 1;
              bit_d = bit_q + 3'd1;
            end
          end
        end
        PAR: begin
          if (tick) begin
            state_d = STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_q == LAST_STOP) begin
              state_d = IDLE;
              acc_d   = '0;
            end else begin
              stop_d = stop_q + 1'b1;
            end
            tx_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A dropped write beats a same-cycle clear.
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign uart_tx    = tx_q;
  assign tx_busy    = (state_q != IDLE);
  assign fifo_full  = full;
  assign fifo_empty = empty;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter SYSCLK_FREQ, default 50000000, system clock frequency in Hz; legal range BAUD_RATE < SYSCLK_FREQ < 2^28.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate in bits/s.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal values 5..8.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1..2.
REQ-006 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, >=2.
REQ-007 clk  input  1  single system clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 wr_data  input  8  byte to transmit; bits above DATA_BITS-1 ignored.
REQ-010 wr_en  input  1  one-cycle write strobe into FIFO.
REQ-011 ovf_clr  input  1  synchronous clear of overflow.
REQ-012 uart_tx  output  1  serial line, registered, idle high.
REQ-013 tx_busy  output  1  high while FSM not IDLE.
REQ-014 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-015 fifo_empty  output  1  FIFO holds 0 entries.
REQ-016 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-017 overflow  output  1  sticky: a write was dropped.

Function
REQ-018 Bit timing SHALL use a phase accumulator (29 bits): each cycle sum = acc + BAUD_RATE; if sum >= SYSCLK_FREQ, tick=1 and acc <= sum - SYSCLK_FREQ, else acc <= sum.
REQ-019 Accumulator SHALL be cleared to 0 on the edge a frame is loaded; average bit length SYSCLK_FREQ/BAUD_RATE cycles, exact when divisible.
REQ-020 FSM states: IDLE, START, DATA, PAR, STOP; PAR skipped when PARITY=0.
REQ-021 IDLE with FIFO non-empty: pop head, load shift register, uart_tx <= 0, go START on same edge.
REQ-022 Write into empty FIFO while IDLE: start bit appears on uart_tx one edge after the write edge.
REQ-023 On each tick: START->DATA driving bit0; DATA shifts LSB-first for DATA_BITS bits; then PAR or STOP; STOP drives 1 for STOP_BITS ticks.
REQ-024 Parity bit = XOR of the DATA_BITS data bits (even) or its inverse (odd).
REQ-025 On final STOP tick: if FIFO non-empty, load next frame on same edge (no idle gap); else go IDLE, uart_tx stays 1.
REQ-026 uart_tx SHALL change only on load edges and tick edges.
REQ-027 Write accepted when not full, or when full and a pop occurs on the same edge; count unchanged on simultaneous push and pop.
REQ-028 Write when full with no pop: data dropped, overflow <= 1; ovf_clr clears overflow, set wins if both same cycle.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; fifo_full/fifo_empty/fifo_count derived from registered occupancy.
REQ-030 wr_en during a frame SHALL not disturb the frame in progress.

Reset
REQ-031 rst_n low SHALL immediately force uart_tx=1, FSM IDLE, accumulator 0, FIFO empty (count 0, empty 1, full 0), overflow 0, tx_busy 0, including mid-frame.
REQ-032 After reset release, no frame starts until a write occurs.

Verification (SYSCLK_FREQ=16, BAUD_RATE=1 unless stated)
REQ-033 8N1, write 0x55 in IDLE -> next edge uart_tx=0 for 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, stop 1 for 16; tx_busy high 160 cycles.
REQ-034 DATA_BITS=7, PARITY=2, STOP_BITS=2, write 0x83 -> data 1,1,0,0,0,0,0, parity 0, stops 1,1; frame 176 cycles.
REQ-035 FIFO_DEPTH=4, transmitter busy, write 5 bytes -> 4 accepted, fifo_full=1, overflow=1, 5th dropped; 4 frames sent back-to-back with no high gap beyond stop bits; ovf_clr then clears overflow.
REQ-036 FIFO_DEPTH=4 full, wr_en on the edge of a pop -> write accepted, fifo_count stays 4, overflow stays 0.
REQ-037 rst_n low during data bit 3 -> uart_tx=1 asynchronously, fifo_count=0, tx_busy=0; after release, line stays high with no write.
REQ-038 SYSCLK_FREQ=10, BAUD_RATE=3, 8N1 -> bit lengths 4,3,3,4,3,3,4,3,3,4 cycles; frame 34 cycles.
